// File: rtl/wb_data_resize_seq.sv
// Wishbone B3 data-width downsizer: each wide master access becomes sequential narrow slave beats, big-endian lanes.
// Optional slave-response watchdog is compiled in when WB_RESIZE_TIMEOUT_EN is defined.
module wb_data_resize_seq #(
  parameter int AW      = 32,
  parameter int MW      = 32,
  parameter int SW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wbm_adr_i,
  input  logic [MW-1:0]   wbm_dat_i,
  input  logic [MW/8-1:0] wbm_sel_i,
  input  logic            wbm_we_i,
  input  logic            wbm_cyc_i,
  input  logic            wbm_stb_i,
  input  logic [2:0]      wbm_cti_i,
  input  logic [1:0]      wbm_bte_i,
  output logic [MW-1:0]   wbm_rdt_o,
  output logic            wbm_ack_o,
  output logic            wbm_err_o,
  output logic            wbm_rty_o,
  output logic [AW-1:0]   wbs_adr_o,
  output logic [SW-1:0]   wbs_dat_o,
  output logic [SW/8-1:0] wbs_sel_o,
  output logic            wbs_we_o,
  output logic            wbs_cyc_o,
  output logic            wbs_stb_o,
  output logic [2:0]      wbs_cti_o,
  output logic [1:0]      wbs_bte_o,
  input  logic [SW-1:0]   wbs_rdt_i,
  input  logic            wbs_ack_i,
  input  logic            wbs_err_i,
  input  logic            wbs_rty_i
);

  localparam int R   = MW / SW;
  localparam int LB  = SW / 8;
  localparam int MB  = MW / 8;
  localparam int LW  = $clog2(R);
  localparam int LBB = $clog2(LB);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [MW-1:0]   dat_q, dat_d;
  logic [MB-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [R-1:0]    pend_q, pend_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [MW-1:0]   rbuf_q, rbuf_d;
  logic [MW-1:0]   rdt_q, rdt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            rty_q, rty_d;
  logic [AW-1:0]   s_adr_q, s_adr_d;
  logic [SW-1:0]   s_dat_q, s_dat_d;
  logic [LB-1:0]   s_sel_q, s_sel_d;
  logic            s_we_q, s_we_d;
  logic            s_cyc_q, s_cyc_d;
  logic            s_stb_q, s_stb_d;
  logic [R-1:0]    pend_left;

`ifdef WB_RESIZE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic unused_cti_bte;
  assign unused_cti_bte = ^{wbm_cti_i, wbm_bte_i};

  function automatic logic [R-1:0] lane_mask(input logic [MB-1:0] sel);
    logic [R-1:0] m;
    m = '0;
    for (int k = 0; k < R; k++) m[k] = |sel[MB-1-k*LB -: LB];
    return m;
  endfunction

  function automatic logic [LW-1:0] first_lane(input logic [R-1:0] m);
    logic [LW-1:0] l;
    l = '0;
    for (int k = R-1; k >= 0; k--) if (m[k]) l = LW'(k);
    return l;
  endfunction

  function automatic logic [SW-1:0] get_dat(input logic [MW-1:0] d, input logic [LW-1:0] l);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < R; k++) if (l == LW'(k)) r = d[MW-1-k*SW -: SW];
    return r;
  endfunction

  function automatic logic [LB-1:0] get_sel(input logic [MB-1:0] s, input logic [LW-1:0] l);
    logic [LB-1:0] r;
    r = '0;
    for (int k = 0; k < R; k++) if (l == LW'(k)) r = s[MB-1-k*LB -: LB];
    return r;
  endfunction

  function automatic logic [MW-1:0] put_dat(input logic [MW-1:0] b, input logic [LW-1:0] l,
                                            input logic [SW-1:0] d);
    logic [MW-1:0] r;
    r = b;
    for (int k = 0; k < R; k++) if (l == LW'(k)) r[MW-1-k*SW -: SW] = d;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    pend_d    = pend_q;
    lane_d    = lane_q;
    rbuf_d    = rbuf_q;
    rdt_d     = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rty_d     = 1'b0;
    pend_left = pend_q & ~(R'(1) << lane_q);
`ifdef WB_RESIZE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d  = wbm_adr_i;
          dat_d  = wbm_dat_i;
          sel_d  = wbm_sel_i;
          we_d   = wbm_we_i;
          pend_d = lane_mask(wbm_sel_i);
          rbuf_d = '0;
          lane_d = first_lane(pend_d);
          if (pend_d == '0) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Abort beats any slave response; err outranks rty outranks ack.
        if (!wbm_cyc_i) begin
          state_d = IDLE;
        end else if (wbs_err_i) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (wbs_rty_i) begin
          state_d = DONE;
          rty_d   = 1'b1;
        end else if (wbs_ack_i) begin
          rbuf_d = put_dat(rbuf_q, lane_q, wbs_rdt_i);
          pend_d = pend_left;
          if (pend_left != '0) begin
            state_d = GAP;
            lane_d  = first_lane(pend_left);
          end else begin
            state_d = DONE;
            ack_d   = 1'b1;
            rdt_d   = rbuf_d;
          end
        end
`ifdef WB_RESIZE_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      GAP:     state_d = wbm_cyc_i ? REQ : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Slave signals are built from the next state so they appear registered with it.
    s_cyc_d = (state_d == REQ) || (state_d == GAP);
    s_stb_d = (state_d == REQ);
    s_adr_d = '0;
    s_dat_d = '0;
    s_sel_d = '0;
    s_we_d  = 1'b0;
    if (s_cyc_d) begin
      s_adr_d = (adr_d & ~AW'(MB-1)) | (AW'(lane_d) << LBB);
      s_dat_d = get_dat(dat_d, lane_d);
      s_sel_d = get_sel(sel_d, lane_d);
      s_we_d  = we_d;
    end
`ifdef WB_RESIZE_TIMEOUT_EN
    if (state_d == REQ && state_q != REQ) cnt_d = '0;
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      pend_q  <= '0;
      lane_q  <= '0;
      rbuf_q  <= '0;
      rdt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_sel_q <= '0;
      s_we_q  <= 1'b0;
      s_cyc_q <= 1'b0;
      s_stb_q <= 1'b0;
`ifdef WB_RESIZE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      rbuf_q  <= rbuf_d;
      rdt_q   <= rdt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_sel_q <= s_sel_d;
      s_we_q  <= s_we_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
`ifdef WB_RESIZE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wbm_rdt_o = rdt_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbm_rty_o = rty_q;
  assign wbs_adr_o = s_adr_q;
  assign wbs_dat_o = s_dat_q;
  assign wbs_sel_o = s_sel_q;
  assign wbs_we_o  = s_we_q;
  assign wbs_cyc_o = s_cyc_q;
  assign wbs_stb_o = s_stb_q;
  assign wbs_cti_o = 3'b000;
  assign wbs_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_data_resize_seq.sv
// Bench for wb_data_resize_seq (MW=32, SW=8): random and directed accesses against a lane-level reference model.
module tb_wb_data_resize_seq;
  localparam int AW = 32;
  localparam int MW = 32;
  localparam int SW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] wbm_adr_i;
  logic [MW-1:0] wbm_dat_i;
  logic [3:0]    wbm_sel_i;
  logic          wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [2:0]    wbm_cti_i;
  logic [1:0]    wbm_bte_i;
  logic [MW-1:0] wbm_rdt_o;
  logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0] wbs_adr_o;
  logic [SW-1:0] wbs_dat_o;
  logic [0:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [SW-1:0] wbs_rdt_i;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;

  always #5 clk = ~clk;

  wb_data_resize_seq #(.AW(AW), .MW(MW), .SW(SW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_rdt_o(wbm_rdt_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_rdt_i(wbs_rdt_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: byte memory, combinational response, optional fault on a chosen beat.
  logic [7:0] tb_mem [256];
  int         fault_beat = 0;
  logic       fault_rty  = 1'b0;
  logic       slv_silent = 1'b0;
  int         beat_base  = 0;
  int         beat_total = 0;
  int         cyc_total  = 0;
  int         gap_err    = 0;
  logic       prev_ack   = 1'b0;
  logic       fault_now;
  logic [AW-1:0] mon_adr [$];
  logic [SW-1:0] mon_dat [$];
  logic          mon_we  [$];
  logic          mon_sel [$];

  always_comb begin
    fault_now = (fault_beat != 0) && (beat_total - beat_base + 1 == fault_beat);
    wbs_ack_i = wbs_cyc_o & wbs_stb_o & ~slv_silent & ~fault_now;
    wbs_err_i = wbs_cyc_o & wbs_stb_o & ~slv_silent & fault_now & ~fault_rty;
    wbs_rty_i = wbs_cyc_o & wbs_stb_o & ~slv_silent & fault_now & fault_rty;
    wbs_rdt_i = tb_mem[wbs_adr_o[7:0]];
  end

  // Beat log, captured from the values settled during the cycle that just ended.
  always @(posedge clk) begin
    if (wbs_cyc_o && wbs_stb_o && (wbs_ack_i || wbs_err_i || wbs_rty_i)) begin
      beat_total <= beat_total + 1;
      mon_adr.push_back(wbs_adr_o);
      mon_dat.push_back(wbs_dat_o);
      mon_we.push_back(wbs_we_o);
      mon_sel.push_back(wbs_sel_o[0]);
    end
    if (wbs_cyc_o) cyc_total <= cyc_total + 1;
    if (prev_ack && wbs_stb_o) gap_err <= gap_err + 1;
    prev_ack <= wbs_stb_o && wbs_ack_i;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One master access checked against the lane model: beats, response kind, latency, read data.
  task automatic run_check(input string name, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic we, input int fbeat, input logic frty);
    logic [31:0] e_adr [$];
    logic [7:0]  e_dat [$];
    logic [31:0] e_rdt, o_rdt;
    logic [2:0]  e_kind, o_kind;
    logic [7:0]  idx;
    int nsel, nb, e_lat, lat, q_base, c_base;
    logic hit;
    nsel = 0;
    for (int k = 0; k < 4; k++) if (sel[3-k]) nsel++;
    hit   = (fbeat != 0) && (fbeat <= nsel);
    nb    = 0;
    e_rdt = '0;
    for (int k = 0; k < 4; k++) begin
      if (sel[3-k] && (!hit || nb < fbeat)) begin
        idx = 8'(adr[7:0] & 8'hFC) + 8'(k);
        e_adr.push_back({adr[31:2], 2'b00} + 32'(k));
        e_dat.push_back(dat[31-8*k -: 8]);
        e_rdt[31-8*k -: 8] = tb_mem[idx];
        nb++;
      end
    end
    if (hit) begin
      e_kind = frty ? 3'b001 : 3'b010;
      e_rdt  = '0;
    end else begin
      e_kind = 3'b100;
    end
    e_lat = (nb == 0) ? 1 : 2 * nb;

    beat_base  = beat_total;
    fault_beat = fbeat;
    fault_rty  = frty;
    q_base     = mon_adr.size();
    c_base     = cyc_total;
    wbm_adr_i  = adr;
    wbm_sel_i  = sel;
    wbm_dat_i  = dat;
    wbm_we_i   = we;
    wbm_cyc_i  = 1'b1;
    wbm_stb_i  = 1'b1;
    lat    = -1;
    o_kind = 3'b000;
    o_rdt  = '0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        lat    = c;
        o_kind = {wbm_ack_o, wbm_err_o, wbm_rty_o};
        o_rdt  = wbm_rdt_o;
        break;
      end
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    tick();
    fault_beat = 0;

    n_checks++;
    if (lat !== e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, e_lat);
    end
    n_checks++;
    if (o_kind !== e_kind) begin
      n_fail++;
      $display("FAIL %s response {ack,err,rty}: got %b, want %b", name, o_kind, e_kind);
    end
    if (e_kind == 3'b100) begin
      n_checks++;
      if (o_rdt !== e_rdt) begin
        n_fail++;
        $display("FAIL %s rdt: got %h, want %h", name, o_rdt, e_rdt);
      end
    end
    n_checks++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s response not one cycle: got %b, want 000", name, {wbm_ack_o, wbm_err_o, wbm_rty_o});
    end
    n_checks++;
    if (cyc_total - c_base !== ((nb == 0) ? 0 : 2 * nb - 1)) begin
      n_fail++;
      $display("FAIL %s slave cyc cycles: got %0d, want %0d", name, cyc_total - c_base,
               (nb == 0) ? 0 : 2 * nb - 1);
    end
    n_checks++;
    if (mon_adr.size() - q_base !== nb) begin
      n_fail++;
      $display("FAIL %s beat count: got %0d, want %0d", name, mon_adr.size() - q_base, nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        n_checks++;
        if ({mon_adr[q_base+i], mon_dat[q_base+i], mon_we[q_base+i], mon_sel[q_base+i]} !==
            {e_adr[i], e_dat[i], we, 1'b1}) begin
          n_fail++;
          $display("FAIL %s beat %0d adr/dat/we/sel: got %h/%h/%b/%b, want %h/%h/%b/1", name, i,
                   mon_adr[q_base+i], mon_dat[q_base+i], mon_we[q_base+i], mon_sel[q_base+i],
                   e_adr[i], e_dat[i], we);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({wbm_rdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o, wbs_dat_o, wbs_sel_o,
         wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got nonzero (cyc=%b stb=%b ack=%b), want all 0",
               wbs_cyc_o, wbs_stb_o, wbm_ack_o);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o, wbs_stb_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL post-reset idle: got %b, want 00000",
               {wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o, wbs_stb_o});
    end
  endtask

  task automatic test_directed();
    run_check("write4", 32'h9000_0000, 4'b1111, 32'h1122_3344, 1'b1, 0, 1'b0);
    tb_mem[8'h06] = 8'hAA;
    tb_mem[8'h07] = 8'hBB;
    run_check("read2", 32'h9000_0004, 4'b0011, 32'h0, 1'b0, 0, 1'b0);
    run_check("zero_sel", 32'h9000_0008, 4'b0000, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_err_rty();
    run_check("err_beat2", 32'h9000_000C, 4'b1111, 32'hA1B2_C3D4, 1'b1, 2, 1'b0);
    n_checks++;
    if (wbs_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_idle cyc: got %b, want 0", wbs_cyc_o);
    end
    run_check("rty_beat2", 32'h9000_0010, 4'b1111, 32'h5566_7788, 1'b1, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      int fb;
      a  = 32'h9000_0000 | (32'($urandom_range(0, 63)) << 2);
      fb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      run_check("random", a, 4'($urandom), $urandom, 1'($urandom), fb, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int first, second, b0;
    first  = -1;
    second = -1;
    b0     = beat_total;
    beat_base = beat_total;
    wbm_adr_i = 32'h9000_0040;
    wbm_sel_i = 4'b1111;
    wbm_dat_i = 32'h0;
    wbm_we_i  = 1'b0;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (wbm_ack_o) begin
        if (first < 0) first = c;
        else begin
          second = c;
          break;
        end
      end
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    tick();
    n_checks++;
    if (first !== 8 || second !== 17) begin
      n_fail++;
      $display("FAIL b2b ack cycles: got %0d,%0d, want 8,17", first, second);
    end
    n_checks++;
    if (beat_total - b0 !== 8) begin
      n_fail++;
      $display("FAIL b2b beats: got %0d, want 8", beat_total - b0);
    end
  endtask

  task automatic test_silent_slave();
    int rise, resp, stb_hi;
    rise   = -1;
    resp   = -1;
    stb_hi = 0;
    slv_silent = 1'b1;
    wbm_adr_i = 32'h9000_0050;
    wbm_sel_i = 4'b1111;
    wbm_dat_i = 32'hCAFE_F00D;
    wbm_we_i  = 1'b1;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
`ifdef WB_RESIZE_TIMEOUT_EN
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (wbs_stb_o && rise < 0) rise = c;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        resp = wbm_err_o ? c : -2;
        break;
      end
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    n_checks++;
    if (rise !== 1 || resp !== rise + 17) begin
      n_fail++;
      $display("FAIL timeout err: stb rise %0d err at %0d, want 1 and 18", rise, resp);
    end
    tick();
`else
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (wbs_stb_o) stb_hi++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) resp = c;
    end
    n_checks++;
    if (stb_hi !== 1000 || resp !== -1) begin
      n_fail++;
      $display("FAIL stall: stb high %0d cycles, response at %0d, want 1000 and none", stb_hi, resp);
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    tick();
    n_checks++;
    if ({wbs_cyc_o, wbs_stb_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort: cyc/stb %b, want 00", {wbs_cyc_o, wbs_stb_o});
    end
    tick();
    n_checks++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort response: got %b, want 000", {wbm_ack_o, wbm_err_o, wbm_rty_o});
    end
`endif
    slv_silent = 1'b0;
  endtask

  task automatic test_reset_midbeat();
    int seen;
    seen = 0;
    beat_base = beat_total;
    wbm_adr_i = 32'h9000_0060;
    wbm_sel_i = 4'b1111;
    wbm_dat_i = 32'h0102_0304;
    wbm_we_i  = 1'b1;
    wbm_cyc_i = 1'b1;
    wbm_stb_i = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (beat_total - beat_base == 2 && wbs_stb_o) begin
        seen = 1;
        break;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (seen !== 1 || {wbm_rdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_adr_o, wbs_dat_o,
                       wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o} !== '0) begin
      n_fail++;
      $display("FAIL midbeat reset: beat3 seen=%0d cyc=%b stb=%b adr=%h, want 1 and all 0",
               seen, wbs_cyc_o, wbs_stb_o, wbs_adr_o);
    end
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL after reset release: got %b, want 0000",
               {wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_cyc_o});
    end
    tb_mem[8'h21] = 8'h5A;
    run_check("read1_after_reset", 32'h9000_0020, 4'b0100, 32'h0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'($urandom);
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_sel_i = '0;
    wbm_we_i  = 1'b0;
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_cti_i = 3'b000;
    wbm_bte_i = 2'b00;
    test_reset();
    test_directed();
    test_err_rty();
    test_random();
    test_back_to_back();
    test_silent_slave();
    test_reset_midbeat();
    n_checks++;
    if (gap_err !== 0) begin
      n_fail++;
      $display("FAIL stb gap: %0d back-to-back strobes after ack, want 0", gap_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_data_resize_seq.md
Name: wb_data_resize_seq

Overview:
- Parametrised Wishbone B3 data-width downsizer. One wide master port (CPU side, via wb_intercon) drives one narrow slave port (peripheral side, e.g. the 8-bit UART).
- Unlike a purely combinational resizer, it splits any multi-byte master access into sequential narrow slave beats. It collects read lanes and returns one master ack, err or rty per master access.
- Byte ordering is big-endian, matching OR1200.

Parameters:
- AW, 32, address width of both ports.
- MW, 32, master data width; legal values 16, 32, 64.
- SW, 8, slave data width; legal values 8, 16, 32; SW < MW, MW % SW == 0.
- TIMEOUT, 255, slave-response watchdog limit in cycles; used only when the optional feature is compiled in.
- Derived: R = MW/SW lanes; LB = SW/8 bytes per lane.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbm_adr_i  in  AW  master address
- wbm_dat_i  in  MW  master write data
- wbm_sel_i  in  MW/8  master byte selects
- wbm_we_i  in  1  write enable
- wbm_cyc_i  in  1  cycle
- wbm_stb_i  in  1  strobe
- wbm_cti_i  in  3  ignored; every access is treated as classic
- wbm_bte_i  in  2  ignored
- wbm_rdt_o  out  MW  read data
- wbm_ack_o  out  1  ack
- wbm_err_o  out  1  error
- wbm_rty_o  out  1  retry
- wbs_adr_o  out  AW  slave address
- wbs_dat_o  out  SW  slave write data
- wbs_sel_o  out  LB  slave byte selects
- wbs_we_o  out  1  slave write enable
- wbs_cyc_o  out  1  slave cycle
- wbs_stb_o  out  1  slave strobe
- wbs_cti_o  out  3  constant 3'b000
- wbs_bte_o  out  2  constant 2'b00
- wbs_rdt_i  in  SW  slave read data
- wbs_ack_i  in  1  slave ack
- wbs_err_i  in  1  slave error
- wbs_rty_i  in  1  slave retry

Behaviour:
- Reset:
  - wb_rst_i high clears all state immediately, independent of the clock; the FSM returns to IDLE.
  - All registered outputs are 0 during and after reset: wbm_rdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o, and every wbs_* output.
  - Reset asserted mid-beat drops wbs_cyc_o/wbs_stb_o at once; no master response is issued.
- All outputs are registered.
- Lane mapping, lane k = 0..R-1, k = 0 at the lowest address:
  - Data bits: [MW-1-k*SW -: SW].
  - Select bits: [MW/8-1-k*LB -: LB].
  - Slave address: {wbm_adr_i[AW-1:log2(MW/8)], k, log2(LB) zero bits}.
- FSM states:
  - IDLE: accept when wbm_cyc_i & wbm_stb_i. Latch adr, dat, sel and we. Build the pending lane mask: a lane is pending if any of its sel bits is set. Clear the read buffer. If the mask is zero, go to DONE; otherwise go to REQ with the lowest pending lane.
  - REQ: wbs_cyc_o = wbs_stb_o = 1. Hold the lane's adr, dat, sel and we stable until wbs_ack_i, wbs_err_i or wbs_rty_i.
    - On ack: store wbs_rdt_i into the lane's slice of the read buffer and clear the lane's pending bit. Go to GAP if lanes remain, else DONE.
    - On err or rty: abort remaining lanes and go to DONE with that status.
    - Priority when several are high together: err > rty > ack.
  - GAP: one cycle with wbs_stb_o = 0 and wbs_cyc_o = 1, then REQ on the next pending lane. The gap guarantees registered-ack slaves never double-ack.
  - DONE: exactly one one-cycle pulse of wbm_ack_o, wbm_err_o or wbm_rty_o. wbs_cyc_o = 0. wbm_rdt_o = read buffer, valid only in the ack cycle. Next state IDLE.
- Latency:
  - Master request sampled at cycle 0 gives slave stb at cycle 1.
  - A combinational slave ack at cycle 1 advances to the next lane's stb at cycle 3.
  - Master ack arrives one cycle after the final slave ack.
  - With a zero mask, master ack arrives at cycle 1.
- Read data: unselected lanes return 0.
- Master abort: wbm_cyc_i low in REQ or GAP gives wbs_cyc_o = wbs_stb_o = 0 next cycle and a return to IDLE with no master response. Late slave responses are ignored.
- A master holding stb after its ack is accepted as a new access in the cycle after DONE.

Optional Feature:
- Macro WB_RESIZE_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without a slave response.
  - When the count reaches TIMEOUT, the current beat and remaining lanes are abandoned and the FSM goes to DONE with wbm_err_o.
- When undefined: no counter is built; REQ waits indefinitely.

Test Plan:
- Write, MW=32, SW=8, adr 0x90000000, sel 4'b1111, dat 0x11223344, combinational slave ack -> four beats at adr 0x90000000..0x90000003 with data 0x11, 0x22, 0x33, 0x44. stb low one cycle between beats. Exactly one wbm_ack_o, one cycle after the fourth ack.
- Read, adr 0x90000004, sel 4'b0011, slave returns 0xAA at 0x90000006 and 0xBB at 0x90000007 -> exactly 2 beats; wbm_rdt_o = 0x0000AABB in the ack cycle.
- sel 4'b0000 read -> wbs_cyc_o never asserts; wbm_ack_o at cycle 1; wbm_rdt_o = 0.
- Write, sel 4'b1111, wbs_err_i on beat 2 -> only 2 beats issued; one wbm_err_o pulse; no wbm_ack_o; FSM back in IDLE. Repeat with wbs_rty_i -> one wbm_rty_o pulse.
- wb_rst_i asserted mid-beat 3 -> all outputs 0 in the same cycle. After release, a 1-byte read (sel 4'b0100, slave data 0x5A) completes with wbm_rdt_o = 0x005A0000.
- WB_RESIZE_TIMEOUT_EN defined, TIMEOUT=16, slave silent -> wbm_err_o pulses 17 cycles after wbs_stb_o rises. Macro undefined -> wbs_stb_o stays high for 1000 cycles with no master response.
